// File: rtl/store_write_buffer.sv
// store_write_buffer: lane-aligning store FIFO draining to the memory write port; optional WB_COALESCE_EN merges same-word stores into the newest entry
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_we,
    output logic        st_ready,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_we,
    output logic        buf_empty
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [29:0] waddr_q [DEPTH];
    logic [31:0] data_q  [DEPTH];
    logic [3:0]  we_q    [DEPTH];
    logic [AW:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail;
    logic accept, push, pop, merge;
    logic [31:0] st_aligned, merged;
    logic unused_ok;

    assign unused_ok     = ^{st_addr[1:0], ld_addr[1:0]};
    assign st_ready      = count_q != FULL;
    assign mem_req_valid = count_q != '0;
    assign buf_empty     = count_q == '0;
    assign accept        = st_valid && st_ready && (st_we != 4'b0000);
    assign pop           = mem_req_valid && mem_req_ready;
    assign tail          = wr_ptr_q - 1'b1;
`ifdef WB_COALESCE_EN
    assign merge = accept && (count_q >= (AW+1)'(2)) && (waddr_q[tail] == st_addr[31:2]);
`else
    assign merge = 1'b0;
`endif
    assign push     = accept && !merge;
    assign mem_addr = mem_req_valid ? {waddr_q[rd_ptr_q], 2'b00} : '0;
    assign mem_data = mem_req_valid ? data_q[rd_ptr_q] : '0;
    assign mem_we   = mem_req_valid ? we_q[rd_ptr_q] : '0;

    // Replicate the narrow store value across every lane it may target
    always_comb begin
        st_aligned = (st_we == 4'b1111) ? st_data :
                     (st_we == 4'b1100 || st_we == 4'b0011) ? {2{st_data[15:0]}} :
                     $onehot(st_we) ? {4{st_data[7:0]}} : st_data;
    end

    // Overlay the incoming lanes onto the newest entry for a coalescing store
    always_comb begin
        for (int k = 0; k < 4; k++)
            merged[8*k +: 8] = st_we[k] ? st_aligned[8*k +: 8] : data_q[tail][8*k +: 8];
    end

    // Next occupancy and pointers; a merge consumes no slot
    always_comb begin
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
    end

    // Word-address match against occupied slots and the store being accepted
    always_comb begin
        ld_hit = accept && (st_addr[31:2] == ld_addr[31:2]);
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, AW'(i) - rd_ptr_q} < count_q && waddr_q[i] == ld_addr[31:2])
                ld_hit = 1'b1;
    end

    // Occupancy and pointer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage: allocate at the tail or merge into the newest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                data_q[i]  <= '0;
                we_q[i]    <= '0;
            end
        end else if (push) begin
            waddr_q[wr_ptr_q] <= st_addr[31:2];
            data_q[wr_ptr_q]  <= st_aligned;
            we_q[wr_ptr_q]    <= st_we;
        end else if (merge) begin
            data_q[tail] <= merged;
            we_q[tail]   <= we_q[tail] | st_we;
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed checks of store_write_buffer
module tb_store_write_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_we = '0;
    logic        st_ready;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_we;
    logic        buf_empty;
    int checks = 0;
    int failures = 0;

    store_write_buffer dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr),
        .st_data(st_data), .st_we(st_we), .st_ready(st_ready),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .buf_empty(buf_empty)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_we    = w;
    endtask

    task automatic test_reset();
        cyc();
        checks++;
        if ({st_ready, buf_empty, mem_req_valid} !== 3'b110) begin
            failures++;
            $display("FAIL reset_flags got=%b want=110", {st_ready, buf_empty, mem_req_valid});
        end
        checks++;
        if ({mem_addr, mem_data, mem_we} !== 68'h0) begin
            failures++;
            $display("FAIL reset_head got=%h/%h/%h want=0", mem_addr, mem_data, mem_we);
        end
        rst = 1'b0;
        cyc();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4*i), 32'hC0 + 32'(i), 4'hF);
            cyc();
        end
        drive(1'b0, 0, 0, 0);
        mem_req_ready = 1'b1;
        cyc();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h304) begin
            failures++;
            $display("FAIL middrain_head got=%b/%h want=1/00000304", mem_req_valid, mem_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, buf_empty, st_ready} !== 3'b011) begin
            failures++;
            $display("FAIL async_reset got=%b want=011", {mem_req_valid, buf_empty, st_ready});
        end
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if ({mem_req_valid, buf_empty, st_ready, mem_we} !== 7'b0110000) begin
            failures++;
            $display("FAIL post_reset got=%b want=0110000", {mem_req_valid, buf_empty, st_ready, mem_we});
        end
        mem_req_ready = 1'b0;
    endtask

    task automatic test_sb();
        mem_req_ready = 1'b1;
        drive(1'b1, 32'h1000_0002, 32'h0000_00AB, 4'b0010);
        cyc();
        drive(1'b0, 0, 0, 0);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h1000_0000 || mem_data !== 32'hABAB_ABAB || mem_we !== 4'b0010) begin
            failures++;
            $display("FAIL sb_head got=%b/%h/%h/%b want=1/10000000/ababab ab/0010", mem_req_valid, mem_addr, mem_data, mem_we);
        end
        cyc();
        checks++;
        if (buf_empty !== 1'b1 || mem_req_valid !== 1'b0 || mem_data !== 32'h0) begin
            failures++;
            $display("FAIL sb_popped got=%b/%b/%h want=1/0/0", buf_empty, mem_req_valid, mem_data);
        end
        drive(1'b1, 32'h0000_0010, 32'h0000_1234, 4'b1100);
        cyc();
        drive(1'b0, 0, 0, 0);
        checks++;
        if (mem_data !== 32'h1234_1234 || mem_we !== 4'b1100) begin
            failures++;
            $display("FAIL sh_align got=%h/%b want=12341234/1100", mem_data, mem_we);
        end
        cyc();
        drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0110);
        cyc();
        drive(1'b0, 0, 0, 0);
        checks++;
        if (mem_data !== 32'hDEAD_BEEF || mem_we !== 4'b0110) begin
            failures++;
            $display("FAIL odd_mask got=%h/%b want=deadbeef/0110", mem_data, mem_we);
        end
        cyc();
        mem_req_ready = 1'b0;
    endtask

    task automatic test_full();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st_ready !== 1'b1) begin
                failures++;
                $display("FAIL fill_ready[%0d] got=%b want=1", i, st_ready);
            end
            drive(1'b1, 32'h100 + 32'(4*i), 32'hD000_0000 + 32'(i), 4'hF);
            cyc();
        end
        checks++;
        if (st_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got=%b want=0", st_ready);
        end
        drive(1'b1, 32'h110, 32'hD000_0004, 4'hF);
        cyc();
        checks++;
        if (st_ready !== 1'b0 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL held_store got=%b/%h want=0/00000100", st_ready, mem_addr);
        end
        mem_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h100 + 32'(4*k) || mem_data !== 32'hD000_0000 + 32'(k)) begin
                failures++;
                $display("FAIL drain[%0d] got=%b/%h/%h want=1/%h/%h", k, mem_req_valid, mem_addr, mem_data, 32'h100 + 32'(4*k), 32'hD000_0000 + 32'(k));
            end
            cyc();
            if (k == 0) begin
                checks++;
                if (st_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_after_pop got=%b want=1", st_ready);
                end
            end
            if (k == 1) drive(1'b0, 0, 0, 0);
        end
        checks++;
        if (buf_empty !== 1'b1) begin
            failures++;
            $display("FAIL full_drained got=%b want=1", buf_empty);
        end
        mem_req_ready = 1'b0;
    endtask

    task automatic test_zero_we();
        drive(1'b1, 32'h4000_0000, 32'h1234_5678, 4'b0000);
        ld_addr = 32'h4000_0000;
        #1;
        checks++;
        if (ld_hit !== 1'b0) begin
            failures++;
            $display("FAIL zero_we_hit got=%b want=0", ld_hit);
        end
        cyc();
        cyc();
        drive(1'b0, 0, 0, 0);
        checks++;
        if ({buf_empty, mem_req_valid, st_ready} !== 3'b101) begin
            failures++;
            $display("FAIL zero_we got=%b want=101", {buf_empty, mem_req_valid, st_ready});
        end
        ld_addr = '0;
    endtask

    task automatic test_ld_hit();
        mem_req_ready = 1'b0;
        drive(1'b1, 32'h2000_0004, 32'h0BAD_F00D, 4'hF);
        ld_addr = 32'h2000_0007;
        #1;
        checks++;
        if (ld_hit !== 1'b1) begin
            failures++;
            $display("FAIL hit_incoming got=%b want=1", ld_hit);
        end
        cyc();
        drive(1'b0, 0, 0, 0);
        #1;
        checks++;
        if (ld_hit !== 1'b1) begin
            failures++;
            $display("FAIL hit_pending got=%b want=1", ld_hit);
        end
        ld_addr = 32'h2000_0008;
        #1;
        checks++;
        if (ld_hit !== 1'b0) begin
            failures++;
            $display("FAIL hit_next_word got=%b want=0", ld_hit);
        end
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        ld_addr = 32'h2000_0004;
        #1;
        checks++;
        if (ld_hit !== 1'b0 || buf_empty !== 1'b1) begin
            failures++;
            $display("FAIL hit_after_drain got=%b/%b want=0/1", ld_hit, buf_empty);
        end
        ld_addr = '0;
    endtask

    task automatic test_coalesce();
        mem_req_ready = 1'b0;
        drive(1'b1, 32'h10, 32'h1122_3344, 4'b1111);
        cyc();
        drive(1'b1, 32'h20, 32'h0000_0055, 4'b1000);
        cyc();
        drive(1'b1, 32'h20, 32'h0000_0066, 4'b0001);
        cyc();
        drive(1'b0, 0, 0, 0);
        checks++;
        if (mem_addr !== 32'h10 || mem_data !== 32'h1122_3344 || mem_we !== 4'hF) begin
            failures++;
            $display("FAIL co_head got=%h/%h/%b want=00000010/11223344/1111", mem_addr, mem_data, mem_we);
        end
        mem_req_ready = 1'b1;
        cyc();
`ifdef WB_COALESCE_EN
        checks++;
        if (mem_addr !== 32'h20 || mem_data !== 32'h5555_5566 || mem_we !== 4'b1001) begin
            failures++;
            $display("FAIL co_merged got=%h/%h/%b want=00000020/55555566/1001", mem_addr, mem_data, mem_we);
        end
        cyc();
        checks++;
        if (buf_empty !== 1'b1) begin
            failures++;
            $display("FAIL co_count got_empty=%b want=1 after 2 pops", buf_empty);
        end
`else
        checks++;
        if (mem_addr !== 32'h20 || mem_data !== 32'h5555_5555 || mem_we !== 4'b1000) begin
            failures++;
            $display("FAIL co_second got=%h/%h/%b want=00000020/55555555/1000", mem_addr, mem_data, mem_we);
        end
        cyc();
        checks++;
        if (buf_empty !== 1'b0 || mem_data !== 32'h6666_6666 || mem_we !== 4'b0001) begin
            failures++;
            $display("FAIL co_third got=%b/%h/%b want=0/66666666/0001", buf_empty, mem_data, mem_we);
        end
        cyc();
        checks++;
        if (buf_empty !== 1'b1) begin
            failures++;
            $display("FAIL co_count got_empty=%b want=1 after 3 pops", buf_empty);
        end
`endif
        mem_req_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sb();
        test_full();
        test_zero_we();
        test_ld_hit();
        test_coalesce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
